// File: rtl/fx_noise_gate.sv
// Stereo-linked noise gate with hysteresis, hold timer and ramped Q15 gain.
// Feeds the compressor input; all state advances on sample_en only.
module fx_noise_gate #(
  parameter int DATA_W     = 16,
  parameter int PARAM_W    = 8,
  parameter int HOLD_SCALE = 64
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic signed [1:0][DATA_W-1:0]    audio_in,
  output logic signed [1:0][DATA_W-1:0]    audio_out,
  input  logic        [PARAM_W-1:0]        fx_threshold,
  input  logic        [PARAM_W-1:0]        fx_attack,
  input  logic        [PARAM_W-1:0]        fx_hold,
  input  logic        [PARAM_W-1:0]        fx_release,
  input  logic                             sample_en,
  output logic        [2:0]                gate_state
);

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    ATTACK  = 3'd1,
    OPEN    = 3'd2,
    HOLD    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam logic [15:0] UNITY = 16'h7FFF;
  localparam logic signed [31:0] OUT_MAX =
    32'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [31:0] OUT_MIN = -OUT_MAX - 32'sd1;

  state_t      state, state_n;
  logic [15:0] gain, gain_n;
  logic [15:0] hold_cnt, hold_n;

  logic [DATA_W-1:0] abs_l, abs_r, peak;
  logic [DATA_W-1:0] open_thr, close_thr;
  logic [15:0]       att_step, rel_step, hold_load;
  logic [16:0]       att_sum;

  logic signed [31:0]       a_ext [2];
  logic signed [31:0]       g_ext;
  logic signed [31:0]       prod  [2];
  logic signed [31:0]       scaled[2];
  logic signed [DATA_W-1:0] sat_out[2];

  // Most negative input folds to full scale so |x| never wraps.
  function automatic logic [DATA_W-1:0] abs_sat(
    input logic signed [DATA_W-1:0] x
  );
    if (x == {1'b1, {(DATA_W-1){1'b0}}})
      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (x < 0)
      return -x;
    else
      return x;
  endfunction

  always_comb begin
    abs_l     = abs_sat(audio_in[0]);
    abs_r     = abs_sat(audio_in[1]);
    peak      = (abs_l > abs_r) ? abs_l : abs_r;
    open_thr  = DATA_W'({fx_threshold, 7'd0});
    close_thr = open_thr >> 1;
    att_step  = 16'd64 + (16'(fx_attack) << 4);
    rel_step  = 16'd4 + (16'(fx_release) << 2);
    hold_load = 16'(fx_hold) * 16'(HOLD_SCALE);
    att_sum   = {1'b0, gain} + {1'b0, att_step};
  end

  always_comb begin
    state_n = state;
    gain_n  = gain;
    hold_n  = hold_cnt;
    unique case (state)
      CLOSED: begin
        gain_n = '0;
        if (peak >= open_thr)
          state_n = ATTACK;
      end
      ATTACK: begin
        if (att_sum >= {1'b0, UNITY}) begin
          gain_n  = UNITY;
          state_n = OPEN;
        end else begin
          gain_n = att_sum[15:0];
        end
      end
      OPEN: begin
        gain_n = UNITY;
        if (peak < close_thr) begin
          if (fx_hold == '0) begin
            state_n = RELEASE;
          end else begin
            state_n = HOLD;
            hold_n  = hold_load;
          end
        end
      end
      HOLD: begin
        gain_n = UNITY;
        if (peak >= open_thr)
          state_n = OPEN;
        else if (hold_cnt == 16'd1)
          state_n = RELEASE;
        else
          hold_n = hold_cnt - 16'd1;
      end
      RELEASE: begin
        if (peak >= open_thr) begin
          state_n = ATTACK;
        end else if (gain <= rel_step) begin
          gain_n  = '0;
          state_n = CLOSED;
        end else begin
          gain_n = gain - rel_step;
        end
      end
      default: begin
        state_n = CLOSED;
        gain_n  = '0;
      end
    endcase
  end

  // Q15 multiply with the pre-update gain; >>> floors toward -inf.
  always_comb begin
    g_ext = $signed({16'd0, gain});
    for (int c = 0; c < 2; c++) begin
      a_ext[c]  = 32'($signed(audio_in[c]));
      prod[c]   = a_ext[c] * g_ext;
      scaled[c] = prod[c] >>> 15;
      if (scaled[c] > OUT_MAX)
        sat_out[c] = OUT_MAX[DATA_W-1:0];
      else if (scaled[c] < OUT_MIN)
        sat_out[c] = OUT_MIN[DATA_W-1:0];
      else
        sat_out[c] = scaled[c][DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= CLOSED;
      gain      <= '0;
      hold_cnt  <= '0;
      audio_out <= '0;
    end else if (sample_en) begin
      state        <= state_n;
      gain         <= gain_n;
      hold_cnt     <= hold_n;
      audio_out[0] <= sat_out[0];
      audio_out[1] <= sat_out[1];
    end
  end

  assign gate_state = state;

endmodule

// File: doc/fx_noise_gate.md
Name: fx_noise_gate

Overview:
Stereo-linked noise gate that sits directly upstream of fx_compressor in the effects chain. It consumes the raw stereo sample stream and drives the compressor's audio_in. When the linked peak level is below threshold, it mutes the signal with a ramped Q15 gain. Gain opening and closing are controlled by a 5-state machine with hysteresis, a hold timer, and attack/release ramps. All state advances only on sample_en.

Parameters:
DATA_W, 16, sample width (two's complement)
PARAM_W, 8, width of each fx_* control
HOLD_SCALE, 64, number of samples per fx_hold LSB

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
audio_in  input  [1:0][DATA_W-1:0] signed  stereo in; [0]=L, [1]=R
audio_out  output  [1:0][DATA_W-1:0] signed  gated stereo out, registered
fx_threshold  input  PARAM_W  open threshold control
fx_attack  input  PARAM_W  gain opening speed
fx_hold  input  PARAM_W  hold time, in units of HOLD_SCALE samples
fx_release  input  PARAM_W  gain closing speed
sample_en  input  1  one-cycle strobe per audio sample
gate_state  output  3  current FSM state, for debug/metering

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (reset_n), and it takes priority over sample_en.
- Reset values: state=CLOSED (0), gain=0, hold_cnt=0, audio_out=0.
- gate_state encoding: CLOSED=0, ATTACK=1, OPEN=2, HOLD=3, RELEASE=4.
- When sample_en=0, every register holds its value. Parameters are sampled only on sample_en.
- Level detection: abs_x=|x|, with -32768 saturating to 32767. peak=max(abs_L, abs_R).
- Thresholds and steps:
  - open_thr={fx_threshold,7'd0}, range 0..32640.
  - close_thr=open_thr>>1 (hysteresis).
  - att_step=64+(fx_attack<<4), range 64..4144.
  - rel_step=4+(fx_release<<2), range 4..1024.
- Per sample_en, the action depends on the current state:
  - CLOSED: gain stays 0. If peak>=open_thr, go to ATTACK.
  - ATTACK: gain=min(gain+att_step, 32767). If the new gain is 32767, go to OPEN. Peak is ignored while in ATTACK.
  - OPEN: gain=32767. If peak<close_thr:
    - fx_hold==0: go to RELEASE.
    - otherwise: go to HOLD and load hold_cnt=fx_hold*HOLD_SCALE.
  - HOLD: gain stays 32767.
    - If peak>=open_thr, go to OPEN.
    - Else if hold_cnt==1, go to RELEASE.
    - Else hold_cnt decrements.
    - HOLD therefore lasts exactly fx_hold*HOLD_SCALE samples. Changing fx_hold mid-HOLD does not reload hold_cnt.
  - RELEASE:
    - If peak>=open_thr, go to ATTACK with gain unchanged (retrigger from the current gain, no jump).
    - Else gain=max(gain-rel_step, 0). If the new gain is 0, go to CLOSED.
- Output path:
  - audio_out[c] <= sat16((audio_in[c] * $signed({1'b0,gain})) >>> 15).
  - Uses the gain value before this sample's update.
  - Product is 32-bit signed; the arithmetic shift truncates toward -inf.
  - Latency is one sample_en.
  - Unity gain is 32767, so +16384 maps to 16383 and -32768 maps to -32767.
- fx_threshold=0: open_thr=0. The gate opens on the first sample and never leaves OPEN.
- Gain register is 16 bits unsigned; values above 32767 are never stored.

Test Plan:
- Reset, then fx_threshold=0x40 (open 8192, close 4096) and fx_attack=255. Drive L=R=0x4000 for 10 sample_en.
  - Sample 1: CLOSED→ATTACK, out=0.
  - Gain sequence: 4144, 8288, …, 29008, then 32767 at sample 9 (state OPEN).
  - Sample-10 out=0x3FFF on both channels.
- Hysteresis, same threshold: ±1000 input stays CLOSED with out=0 indefinitely. ±6000 input applied while OPEN stays OPEN with out=5999/-6000.
- Hold: from OPEN, fx_hold=2, drop input to 0.
  - gate_state=HOLD for exactly 128 sample_en, then RELEASE.
  - fx_release=255 (step 1024): reaches CLOSED after 32 RELEASE samples (gain 32767→0).
- Retrigger: in HOLD at count 50, input 0x4000 → OPEN on that sample. In RELEASE at gain 20000, input 0x4000 → ATTACK, next gain 20000+att_step.
- Extremes and freeze:
  - L=-32768, fx_threshold=0, gate OPEN → out L=-32767.
  - Hold sample_en low for 100 cycles → all outputs and gate_state are unchanged.
- Mid-ramp reset: assert reset_n=0 during ATTACK for 1 clk (no sample_en) → next cycle gate_state=0, audio_out=0, and gain restarts from 0.
